// File: rtl/wb_frame_reader.sv
// wb_frame_reader: classic Wishbone master that reads NB_WORDS words
// from BASE_ADR into a show-ahead FIFO, optionally looping.
module wb_frame_reader #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter int          NB_WORDS   = 2048,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          loop,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [3:0]                    wb_sel,
  output logic [31:0]                   wb_adr,
  output logic [31:0]                   wb_dat_ms,
  input  logic [31:0]                   wb_dat_sm,
  input  logic                          wb_ack,
  input  logic                          wb_err,
  input  logic                          wb_rty,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic [31:0]     adr_q, adr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW:0]     wr_q, wr_d;
  logic [AW:0]     rd_q, rd_d;

  logic [31:0]     mem [FIFO_DEPTH];
  logic            push;
  logic            pop;
  logic            clr;
  logic            space;
  logic            last;

  function automatic logic [31:0] adr_of(input logic [IW-1:0] i);
    return BASE_ADR + (32'(i) << 2);
  endfunction

  assign level    = wr_q - rd_q;
  assign rd_valid = (level != '0);
  assign rd_data  = rd_valid ? mem[rd_q[AW-1:0]] : '0;
  assign pop      = rd_en && rd_valid;
  assign space    = (level < LW'(FIFO_DEPTH));
  assign last     = (idx_q == IW'(NB_WORDS - 1));

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_adr    = adr_q;
  assign wb_sel    = stb_q ? 4'hF : 4'h0;
  assign wb_we     = 1'b0;
  assign wb_dat_ms = '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          adr_d   = BASE_ADR;
        end
      end
      REQ: begin
        if (stb_q) begin
          // err beats rty beats ack
          unique case (1'b1)
            wb_err: begin
              err_d   = 1'b1;
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              state_d = IDLE;
            end
            !wb_err && wb_rty: begin
              stb_d = 1'b0;
            end
            !wb_err && !wb_rty && wb_ack: begin
              push  = 1'b1;
              stb_d = 1'b0;
              if (!last) begin
                idx_d = idx_q + IW'(1);
              end else if (loop) begin
                idx_d = '0;
              end else begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                done_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (space) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          adr_d = adr_of(idx_q);
        end else begin
          state_d = WAIT_SPACE;
          cyc_d   = 1'b0;
        end
      end
      WAIT_SPACE: begin
        if (space) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          adr_d   = adr_of(idx_q);
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      wr_d = wr_q + (AW+1)'(push);
      rd_d = rd_q + (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q[AW-1:0]] <= wb_dat_sm;
    end
  end

endmodule

// File: doc/wb_frame_reader.md
WB_FRAME_READER -- requirements
Module: wb_frame_reader

Interface
REQ-001 Parameter BASE_ADR, default 32'h0000_0000, byte address of the first word read; SHALL be 4-byte aligned.
REQ-002 Parameter NB_WORDS, default 2048, number of 32-bit words per frame; SHALL be >= 1.
REQ-003 Parameter FIFO_DEPTH, default 16, internal FIFO entries; SHALL be a power of two, >= 2.
REQ-004 Ports SHALL be:
 clk  in  1  single clock; all logic on rising edge.
 rst_n  in  1  asynchronous reset, active-low.
 start  in  1  one-cycle request to read one frame.
 loop  in  1  sampled at last word: 1 restarts at BASE_ADR, 0 stops.
 busy  out  1  high while not IDLE.
 done  out  1  one-cycle pulse after the last word of a non-looped frame.
 error  out  1  sticky bus-error flag.
 wb_cyc  out  1  Wishbone cycle.
 wb_stb  out  1  Wishbone strobe.
 wb_we  out  1  write enable, constant 0.
 wb_sel  out  4  byte selects, 4'hF during requests.
 wb_adr  out  32  byte address.
 wb_dat_ms  out  32  master data, constant 0.
 wb_dat_sm  in  32  slave read data.
 wb_ack  in  1  slave acknowledge.
 wb_err  in  1  slave error.
 wb_rty  in  1  slave retry.
 rd_en  in  1  consumer pop request.
 rd_data  out  32  FIFO head word (show-ahead).
 rd_valid  out  1  FIFO not empty.
 level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-005 States SHALL be IDLE, REQ, WAIT_SPACE; classic (non-pipelined) Wishbone, at most one outstanding access.
REQ-006 IDLE: start=1 SHALL empty the FIFO, load word index 0, enter REQ next cycle; start outside IDLE SHALL be ignored.
REQ-007 REQ entry SHALL require level < FIFO_DEPTH; otherwise go to WAIT_SPACE, wb_cyc=wb_stb=0, return to REQ once level < FIFO_DEPTH.
REQ-008 In REQ, wb_cyc=wb_stb=1, wb_adr=BASE_ADR+4*index; wb_adr, wb_sel, wb_stb SHALL stay stable until ack, err or rty is sampled.
REQ-009 wb_ack=1 in REQ SHALL push wb_dat_sm into the FIFO that edge and increment index (address +4).
REQ-010 Ack of index NB_WORDS-1: loop=1 -> index 0, stay in request flow; loop=0 -> IDLE, done=1 next cycle.
REQ-011 After each ack, wb_stb SHALL drop for one cycle before the next request (no back-to-back strobe).
REQ-012 wb_rty=1 SHALL deassert wb_stb one cycle and reissue the same address; no push.
REQ-013 wb_err=1 SHALL set error, deassert wb_cyc/wb_stb, enter IDLE, no push, no done; error cleared only by reset or next accepted start.
REQ-014 ack/err/rty sampled only while wb_stb=1; if several high, priority err > rty > ack.
REQ-015 FIFO: rd_en with rd_valid=1 pops; rd_en when empty ignored; push+pop same cycle keeps level unchanged; push never occurs when full (guaranteed by REQ-007).
REQ-016 Push into empty FIFO SHALL make rd_valid=1 and rd_data valid the following cycle.
REQ-017 level SHALL equal pushes minus pops since last clear, range 0..FIFO_DEPTH.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE, index 0, FIFO empty, and all outputs 0 (busy, done, error, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms, rd_data, rd_valid, level).
REQ-019 Reset during an access SHALL drop wb_cyc/wb_stb immediately; the pending ack is discarded.

Verification
REQ-020 NB_WORDS=8, zero-wait slave with mem[i]=i, consumer always popping, start -> addresses 0x00..0x1C in order, rd_data 0..7, one done pulse, error=0.
REQ-021 FIFO_DEPTH=4, NB_WORDS=8, no pops -> exactly 4 acks, level=4, wb_stb=0 held; pop one -> one new request at next address.
REQ-022 Slave asserts wb_rty on word 3 once -> address 0x0C issued twice, only one push, data order unchanged.
REQ-023 Slave asserts wb_err on word 5 -> error=1, busy=0, done never pulses, level=5 (no pops).
REQ-024 loop=1, NB_WORDS=4 -> addresses 0x0,0x4,0x8,0xC,0x0,... no done; rst_n low mid-access -> wb_cyc=0 same cycle, level=0.
